// File: rtl/accumulate.sv
// ----------------------------------------------------------------------------
// accumulate
//
// Signed saturating accumulator. Sums a stream of signed MAC products into
// one result per kernel window. Each window is seeded with a sign-extended
// bias. Results pass through a 2-entry FIFO, so the product stream stalls
// only when two results are waiting for the downstream consumer.
//
// Parameters
//   MAC_WIDTH   width of the signed input product
//   NUM_WIDTH   width of the signed accumulator and result (> MAC_WIDTH)
//   BIAS_WIDTH  width of the signed bias (< NUM_WIDTH)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous, active-high reset
//   cfg_bias  in   signed bias, sampled when a window's first term is taken
//   up_val    in   product valid
//   up_last   in   final product of a window (qualified by up_val)
//   up_data   in   signed product
//   up_rdy    out  product accepted on up_val & up_rdy
//   dn_val    out  result valid (FIFO non-empty)
//   dn_data   out  signed accumulated result (FIFO head)
//   dn_ovf    out  the window saturated at least once (qualified by dn_val)
//   dn_rdy    in   result consumed on dn_val & dn_rdy
// ----------------------------------------------------------------------------
module accumulate #(
  parameter int MAC_WIDTH  = 32,
  parameter int NUM_WIDTH  = 33,
  parameter int BIAS_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIAS_WIDTH-1:0] cfg_bias,
  input  logic                  up_val,
  input  logic                  up_last,
  input  logic [MAC_WIDTH-1:0]  up_data,
  output logic                  up_rdy,
  output logic                  dn_val,
  output logic [NUM_WIDTH-1:0]  dn_data,
  output logic                  dn_ovf,
  input  logic                  dn_rdy
);

  // The sum carries one extra bit so overflow shows up as a mismatch between
  // the two top bits.
  localparam int SUM_WIDTH = NUM_WIDTH + 1;

  localparam logic [NUM_WIDTH-1:0] SAT_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
  localparam logic [NUM_WIDTH-1:0] SAT_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

  // Window state
  logic                 first_q;
  logic [NUM_WIDTH-1:0] acc_q;
  logic                 ovf_q;

  // Output FIFO: two entries addressed by one-bit pointers
  logic [NUM_WIDTH-1:0] buf_data_q [2];
  logic                 buf_ovf_q  [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [NUM_WIDTH-1:0] base;
  logic [SUM_WIDTH-1:0] sum;
  logic                 pos_sat;
  logic                 neg_sat;
  logic [NUM_WIDTH-1:0] sat_val;
  logic                 next_ovf;

  // up_rdy and dn_val are forced low combinationally while rst is high, so
  // nothing leaks out during the reset cycle itself.
  assign up_rdy  = ~rst & (count_q != 2'd2);
  assign dn_val  = ~rst & (count_q != 2'd0);
  assign dn_data = rst ? '0   : buf_data_q[rd_ptr_q];
  assign dn_ovf  = rst ? 1'b0 : buf_ovf_q[rd_ptr_q];

  assign accept = up_val & up_rdy;
  assign push   = accept & up_last;
  assign pop    = dn_val & dn_rdy;

  always_comb begin
    // NOTE: every output of this block is assigned on every path, starting
    // with defaults, so no latches are inferred.
    base     = acc_q;
    sat_val  = '0;
    next_ovf = ovf_q;
    if (first_q) begin
      base     = {{(NUM_WIDTH-BIAS_WIDTH){cfg_bias[BIAS_WIDTH-1]}}, cfg_bias};
      next_ovf = 1'b0;
    end

    sum = {base[NUM_WIDTH-1], base}
        + {{(SUM_WIDTH-MAC_WIDTH){up_data[MAC_WIDTH-1]}}, up_data};

    pos_sat = ~sum[SUM_WIDTH-1] &  sum[SUM_WIDTH-2];
    neg_sat =  sum[SUM_WIDTH-1] & ~sum[SUM_WIDTH-2];

    if (pos_sat)      sat_val = SAT_MAX;
    else if (neg_sat) sat_val = SAT_MIN;
    else              sat_val = sum[NUM_WIDTH-1:0];

    next_ovf = next_ovf | pos_sat | neg_sat;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      first_q  <= 1'b1;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      // NOTE: the FIFO storage is reset too, because its head drives dn_data
      // directly and must read as zero once reset has been applied.
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_ovf_q[i]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        acc_q   <= sat_val;
        ovf_q   <= next_ovf;
        first_q <= up_last;
      end

      if (push) begin
        buf_data_q[wr_ptr_q] <= sat_val;
        buf_ovf_q[wr_ptr_q]  <= next_ovf;
        wr_ptr_q             <= ~wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// ----------------------------------------------------------------------------
// tb_accumulate
//
// Directed bench for accumulate with default widths. Inputs change on the
// falling edge or 1 time unit after a rising edge; outputs are observed
// away from the rising edge.
// ----------------------------------------------------------------------------
module tb_accumulate;

  localparam int MW = 32;
  localparam int NW = 33;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] cfg_bias;
  logic          up_val;
  logic          up_last;
  logic [MW-1:0] up_data;
  logic          up_rdy;
  logic          dn_val;
  logic [NW-1:0] dn_data;
  logic          dn_ovf;
  logic          dn_rdy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  accumulate #(
    .MAC_WIDTH (MW),
    .NUM_WIDTH (NW),
    .BIAS_WIDTH(BW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_bias(cfg_bias),
    .up_val  (up_val),
    .up_last (up_last),
    .up_data (up_data),
    .up_rdy  (up_rdy),
    .dn_val  (dn_val),
    .dn_data (dn_data),
    .dn_ovf  (dn_ovf),
    .dn_rdy  (dn_rdy)
  );

  always #5 clk = ~clk;

  // Presents one product from the falling edge and holds it until accepted
  // (bounded wait). Returns 1 time unit after the accepting rising edge.
  task automatic send(input logic [MW-1:0] d, input logic l, output int waited);
    @(negedge clk);
    up_val  = 1'b1;
    up_data = d;
    up_last = l;
    waited  = 0;
    while (!up_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++;
    if (!up_rdy) $display("FAIL send_timeout: up_rdy=%0b required 1 within 20 cycles", up_rdy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    up_val  = 1'b0;
    up_last = 1'b0;
  endtask

  // Pops the head entry with a one-cycle dn_rdy pulse.
  task automatic pop_one();
    @(negedge clk);
    dn_rdy = 1'b1;
    @(posedge clk);
    #1;
    dn_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    cfg_bias = '0;
    up_val   = 1'b0;
    up_last  = 1'b0;
    up_data  = '0;
    dn_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({dn_val, dn_ovf, up_rdy, dn_data} !== {3'b000, {NW{1'b0}}})
      $display("FAIL reset_outputs: got val=%0b ovf=%0b rdy=%0b data=%h required all zero",
               dn_val, dn_ovf, up_rdy, dn_data);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (up_rdy !== 1'b1) $display("FAIL reset_release_rdy: got %0b required 1", up_rdy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int w;
    cfg_bias = 16'd5;
    send(32'd10, 1'b0, w);
    send(32'd20, 1'b0, w);
    send(-32'sd3, 1'b1, w);
    total_cnt++;
    if ({dn_val, dn_ovf, dn_data} !== {1'b1, 1'b0, 33'd32})
      $display("FAIL basic_window: got val=%0b ovf=%0b data=%0d required val=1 ovf=0 data=32",
               dn_val, dn_ovf, dn_data);
    else pass_cnt++;
    pop_one();
    total_cnt++;
    if (dn_val !== 1'b0) $display("FAIL basic_pop_empty: got dn_val=%0b required 0", dn_val);
    else pass_cnt++;
  endtask

  task automatic test_pos_sat();
    int w;
    cfg_bias = 16'd0;
    for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, (i == 3), w);
    total_cnt++;
    if ({dn_val, dn_ovf, dn_data} !== {1'b1, 1'b1, 33'h0_FFFF_FFFF})
      $display("FAIL pos_sat: got val=%0b ovf=%0b data=%h required val=1 ovf=1 data=0ffffffff",
               dn_val, dn_ovf, dn_data);
    else pass_cnt++;
    pop_one();
    cfg_bias = 16'd1;
    send(32'd1, 1'b1, w);
    total_cnt++;
    if ({dn_val, dn_ovf, dn_data} !== {1'b1, 1'b0, 33'd2})
      $display("FAIL ovf_cleared: got val=%0b ovf=%0b data=%0d required val=1 ovf=0 data=2",
               dn_val, dn_ovf, dn_data);
    else pass_cnt++;
    pop_one();
  endtask

  task automatic test_neg_sat();
    int w;
    cfg_bias = 16'hFFFF;
    for (int i = 0; i < 3; i++) send(32'h8000_0000, (i == 2), w);
    total_cnt++;
    if ({dn_val, dn_ovf, dn_data} !== {1'b1, 1'b1, 33'h1_0000_0000})
      $display("FAIL neg_sat: got val=%0b ovf=%0b data=%h required val=1 ovf=1 data=100000000",
               dn_val, dn_ovf, dn_data);
    else pass_cnt++;
    pop_one();
  endtask

  task automatic test_backpressure();
    int w;
    cfg_bias = 16'd0;
    dn_rdy   = 1'b0;
    send(32'd1, 1'b1, w);
    send(32'd2, 1'b1, w);
    total_cnt++;
    if ({up_rdy, dn_val, dn_data} !== {1'b0, 1'b1, 33'd1})
      $display("FAIL bp_full: got rdy=%0b val=%0b data=%0d required rdy=0 val=1 data=1",
               up_rdy, dn_val, dn_data);
    else pass_cnt++;
    // Term 3 waits while the FIFO is full; the head must not move.
    @(negedge clk);
    up_val  = 1'b1;
    up_data = 32'd3;
    up_last = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({up_rdy, dn_val, dn_data} !== {1'b0, 1'b1, 33'd1})
      $display("FAIL bp_hold: got rdy=%0b val=%0b data=%0d required rdy=0 val=1 data=1",
               up_rdy, dn_val, dn_data);
    else pass_cnt++;
    dn_rdy = 1'b1;
    @(posedge clk);  // pops 1
    #1;
    total_cnt++;
    if ({up_rdy, dn_val, dn_data} !== {1'b1, 1'b1, 33'd2})
      $display("FAIL bp_pop1: got rdy=%0b val=%0b data=%0d required rdy=1 val=1 data=2",
               up_rdy, dn_val, dn_data);
    else pass_cnt++;
    @(posedge clk);  // pops 2, accepts 3
    #1;
    up_val  = 1'b0;
    up_last = 1'b0;
    total_cnt++;
    if ({dn_val, dn_data} !== {1'b1, 33'd3})
      $display("FAIL bp_pop2: got val=%0b data=%0d required val=1 data=3", dn_val, dn_data);
    else pass_cnt++;
    @(posedge clk);  // pops 3
    #1;
    dn_rdy = 1'b0;
    total_cnt++;
    if (dn_val !== 1'b0) $display("FAIL bp_no_dup: got dn_val=%0b required 0", dn_val);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_window();
    int w;
    cfg_bias = 16'd0;
    send(32'd100, 1'b0, w);
    send(32'd200, 1'b0, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({up_rdy, dn_val} !== 2'b00)
      $display("FAIL mid_rst_outputs: got rdy=%0b val=%0b required 0 0", up_rdy, dn_val);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({up_rdy, dn_val} !== 2'b10)
      $display("FAIL mid_rst_release: got rdy=%0b val=%0b required 1 0", up_rdy, dn_val);
    else pass_cnt++;
    send(32'd7, 1'b1, w);
    total_cnt++;
    if ({dn_val, dn_ovf, dn_data} !== {1'b1, 1'b0, 33'd7})
      $display("FAIL mid_rst_result: got val=%0b ovf=%0b data=%0d required val=1 ovf=0 data=7",
               dn_val, dn_ovf, dn_data);
    else pass_cnt++;
    pop_one();
  endtask

  task automatic test_back_to_back();
    int w;
    int err;
    cfg_bias = 16'd2;
    dn_rdy   = 1'b1;
    err      = 0;
    for (int i = 0; i < 16; i++) begin
      send(MW'(i), 1'b1, w);
      total_cnt++;
      if (w != 0 || {dn_val, up_rdy, dn_data} !== {2'b11, NW'(i + 2)}) begin
        $display("FAIL stream_%0d: got waited=%0d val=%0b rdy=%0b data=%0d required waited=0 val=1 rdy=1 data=%0d",
                 i, w, dn_val, up_rdy, dn_data, i + 2);
        err++;
      end else pass_cnt++;
    end
    @(posedge clk);
    #1;
    dn_rdy = 1'b0;
    total_cnt++;
    if (dn_val !== 1'b0) $display("FAIL stream_drain: got dn_val=%0b required 0", dn_val);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_backpressure();
    test_reset_mid_window();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/accumulate.md
# accumulate

Signed saturating accumulator directly upstream of `rescale`. It sums a stream of signed MAC products into one result per kernel window, seeding each window with a configurable bias. Each result is presented as a `NUM_WIDTH` number with a valid/ready handshake, plus a per-window overflow flag. A 2-entry output buffer absorbs downstream backpressure, so the upstream product stream stalls only when the buffer is full.

## Interface

- `MAC_WIDTH`, 32, width of signed input product
- `NUM_WIDTH`, 33, width of signed accumulator and output; must be > `MAC_WIDTH`
- `BIAS_WIDTH`, 16, width of signed bias
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `cfg_bias`  in  `BIAS_WIDTH`  signed bias, sign-extended to `NUM_WIDTH`
- `up_val`  in  1  product valid
- `up_last`  in  1  marks final product of a window; qualified by `up_val`
- `up_data`  in  `MAC_WIDTH`  signed product
- `up_rdy`  out  1  product accepted when `up_val & up_rdy`
- `dn_val`  out  1  result valid
- `dn_data`  out  `NUM_WIDTH`  signed accumulated result, feeds `rescale` `up_data`
- `dn_ovf`  out  1  window saturated at least once; qualified by `dn_val`
- `dn_rdy`  in  1  result consumed when `dn_val & dn_rdy`

## Operation

- Accept: `up_val & up_rdy`.
- State: `first` (1 = next accepted term opens a window), `acc` (`NUM_WIDTH`), `ovf` sticky bit.
- On accept with `first`=1: base = sign-extend(`cfg_bias`); `ovf` is cleared. `cfg_bias` is sampled only at this cycle.
- On accept with `first`=0: base = `acc`.
- Sum = base + sign-extend(`up_data`), computed at `NUM_WIDTH+1` bits.
- If sum > 2^(`NUM_WIDTH`-1)-1: `acc` = signed max, `ovf` set.
- If sum < -2^(`NUM_WIDTH`-1): `acc` = signed min, `ovf` set.
- Otherwise `acc` = sum. A saturated value is the base for subsequent terms.
- On accept with `up_last`=1:
  - The saturated sum and final ovf are pushed into the output buffer.
  - `first` is set to 1.
  - A single-term window yields bias + term.
- Output buffer: 2 entries, FIFO order.
  - `dn_val` = buffer non-empty; `dn_data`/`dn_ovf` = head entry.
  - `up_rdy` = buffer not full and not in reset. `up_rdy` is low when the buffer holds 2 entries, even for non-last terms.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- `up_val`=0 cycles inside a window are idle; window state is held indefinitely.
- `up_last` without `up_val` is ignored.

## Timing

- Reset values: `dn_val`=0, `dn_data`=0, `dn_ovf`=0, `up_rdy`=0 while `rst`=1.
- Internal reset values: `acc`=0, `ovf`=0, `first`=1, buffer empty.
- `up_rdy`=1 on the first cycle after `rst` deasserts.
- Reset mid-window discards the partial sum and all buffered results. There is no spurious `dn_val`.
- Latency: last term accepted at edge t gives `dn_val`=1 with the result in cycle t+1, provided the buffer was empty.
- Throughput: one term per cycle. With `dn_rdy` held high, back-to-back single-term windows give continuous `dn_val` and `up_rdy` never drops.
- `dn_data`/`dn_ovf` are stable while `dn_val & ~dn_rdy`.
- Full boundary:
  - Two results buffered and `dn_rdy`=0 → `up_rdy`=0 in the next cycle.
  - A pop in cycle c → `up_rdy`=1 in cycle c+1.
- `rescale` has no handshake, so the consumer samples `dn_data` on `dn_val & dn_rdy`.

## Test plan

Defaults apply: `MAC_WIDTH`=32, `NUM_WIDTH`=33, `BIAS_WIDTH`=16.

1. Basic window: bias=5, terms 10, 20, -3 (last on -3) → one cycle after the last accept, `dn_val`=1, `dn_data`=32, `dn_ovf`=0.
2. Positive saturation: bias=0, four terms of 0x7FFFFFFF → `dn_data`=0x0FFFFFFFF, `dn_ovf`=1. A following window of bias=1, term 1 → `dn_data`=2, `dn_ovf`=0.
3. Negative saturation: bias=-1, three terms of 0x80000000 → `dn_data`=0x100000000 (-2^32), `dn_ovf`=1.
4. Backpressure: `dn_rdy`=0, single-term windows of 1, 2, 3 with bias 0 → two results buffered, `up_rdy`=0, term 3 held. Then raise `dn_rdy` → outputs 1, 2, 3 in order with no loss or duplication.
5. Reset mid-window: accept terms 100, 200 (no last), pulse `rst` for one cycle, then bias=0, term 7 last → `dn_data`=7. There is no `dn_val` during or before this result.
6. Streaming: `dn_rdy`=1, 16 consecutive single-term windows, bias=2, terms 0..15 → `dn_data` sequence 2..17 on consecutive cycles. `up_rdy` stays 1 throughout.
